// File: rtl/exe_sequencer.sv
// Matrix execution sequencer: fetches and decodes instruction words and
// steps the matrix ALU units through launch, completion and writeback.
module exe_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic              op_start,
    input  logic              op_done,
    output logic              read_from,
    output logic              add_en,
    output logic              scale_en,
    output logic              mult_en,
    output logic              transpose_en,
    output logic              add_or_sub,
    output logic              write_to_reg,
    output logic              write_to_mem,
    output logic [7:0]        dst_addr,
    output logic [7:0]        src1_addr,
    output logic [7:0]        src2_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SCALE = 5'b00011;
    localparam logic [4:0] OP_MULT  = 5'b00100;
    localparam logic [4:0] OP_TRANS = 5'b00101;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WAIT,
        S_WRITEBACK,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       opcode;
    logic             unused_rsvd;

    assign opcode      = imem_rdata[31:27];
    assign unused_rsvd = ^imem_rdata[26:24];
    assign imem_addr   = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pc           <= '0;
            imem_rd_en   <= 1'b0;
            op_start     <= 1'b0;
            read_from    <= 1'b0;
            add_en       <= 1'b0;
            scale_en     <= 1'b0;
            mult_en      <= 1'b0;
            transpose_en <= 1'b0;
            add_or_sub   <= 1'b0;
            write_to_reg <= 1'b0;
            write_to_mem <= 1'b0;
            dst_addr     <= '0;
            src1_addr    <= '0;
            src2_addr    <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            error        <= 1'b0;
        end else begin
            // single-cycle strobes fall back to zero unless re-armed below
            imem_rd_en   <= 1'b0;
            op_start     <= 1'b0;
            write_to_reg <= 1'b0;
            write_to_mem <= 1'b0;
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc         <= start_addr;
                        imem_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        halted     <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    dst_addr  <= imem_rdata[23:16];
                    src1_addr <= imem_rdata[15:8];
                    src2_addr <= imem_rdata[7:0];
                    unique case (opcode)
                        OP_NOP: begin
                            pc         <= pc + ADDR_W'(1);
                            imem_rd_en <= 1'b1;
                            state      <= S_FETCH;
                        end
                        OP_HALT: begin
                            busy   <= 1'b0;
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end
                        OP_ADD, OP_SUB, OP_SCALE, OP_MULT, OP_TRANS: begin
                            op_start     <= 1'b1;
                            read_from    <= 1'b1;
                            add_en       <= (opcode == OP_ADD) ||
                                            (opcode == OP_SUB);
                            add_or_sub   <= (opcode == OP_SUB);
                            scale_en     <= (opcode == OP_SCALE);
                            mult_en      <= (opcode == OP_MULT);
                            transpose_en <= (opcode == OP_TRANS);
                            state        <= S_EXECUTE;
                        end
                        default: begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                            state <= S_ERROR;
                        end
                    endcase
                end
                S_EXECUTE: state <= S_WAIT;
                S_WAIT: begin
                    if (op_done || cnt == CNT_LAST) begin
                        cnt          <= '0;
                        read_from    <= 1'b0;
                        add_en       <= 1'b0;
                        scale_en     <= 1'b0;
                        mult_en      <= 1'b0;
                        transpose_en <= 1'b0;
                        add_or_sub   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // completion takes priority over a simultaneous timeout
                    if (op_done) begin
                        write_to_reg <= dst_addr[7];
                        write_to_mem <= ~dst_addr[7];
                        state        <= S_WRITEBACK;
                    end else if (cnt == CNT_LAST) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= S_ERROR;
                    end
                end
                S_WRITEBACK: begin
                    cnt        <= '0;
                    pc         <= pc + ADDR_W'(1);
                    imem_rd_en <= 1'b1;
                    state      <= S_FETCH;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_sequencer.sv
// Directed bench for exe_sequencer with a synchronous instruction memory
// model and a hand-driven matrix-unit completion signal.
module tb_exe_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        op_start;
    logic        op_done;
    logic        read_from, add_en, scale_en, mult_en, transpose_en;
    logic        add_or_sub, write_to_reg, write_to_mem;
    logic [7:0]  dst_addr, src1_addr, src2_addr;
    logic [7:0]  pc;
    logic        busy, halted, error;

    logic [31:0] imem [256];
    logic [12:0] ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] RD = 13'h1000;
    localparam logic [12:0] OS = 13'h0800;
    localparam logic [12:0] RF = 13'h0400;
    localparam logic [12:0] AD = 13'h0200;
    localparam logic [12:0] SC = 13'h0100;
    localparam logic [12:0] MU = 13'h0080;
    localparam logic [12:0] SB = 13'h0020;
    localparam logic [12:0] WR = 13'h0010;
    localparam logic [12:0] WM = 13'h0008;
    localparam logic [12:0] BZ = 13'h0004;
    localparam logic [12:0] HL = 13'h0002;
    localparam logic [12:0] ER = 13'h0001;

    exe_sequencer #(.ADDR_W(8), .INSTR_W(32), .TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .op_start     (op_start),
        .op_done      (op_done),
        .read_from    (read_from),
        .add_en       (add_en),
        .scale_en     (scale_en),
        .mult_en      (mult_en),
        .transpose_en (transpose_en),
        .add_or_sub   (add_or_sub),
        .write_to_reg (write_to_reg),
        .write_to_mem (write_to_mem),
        .dst_addr     (dst_addr),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .error        (error)
    );

    assign ctl = {imem_rd_en, op_start, read_from, add_en, scale_en,
                  mult_en, transpose_en, add_or_sub, write_to_reg,
                  write_to_mem, busy, halted, error};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= imem[imem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [12:0] exp);
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, ctl, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem_rdata = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        start_addr = 8'h00;
        op_done = 1'b0;
        step();
        step();
        chk_ctl("reset_ctl", 13'h0);
        chk8("reset_pc", pc, 8'h00);
        chk8("reset_dst", dst_addr, 8'h00);

        // single ADD, completion on third WAIT cycle
        imem[8'h10] = 32'h08850102;
        imem[8'h11] = 32'hF8000000;
        reset = 1'b0;
        start_addr = 8'h10;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t1_fetch", RD | BZ);
        chk8("t1_addr", imem_addr, 8'h10);
        step();
        chk_ctl("t1_decode", BZ);
        step();
        chk_ctl("t1_exec", OS | RF | AD | BZ);
        chk8("t1_src1", src1_addr, 8'h01);
        chk8("t1_src2", src2_addr, 8'h02);
        chk8("t1_dst", dst_addr, 8'h85);
        step();
        chk_ctl("t1_wait1", RF | AD | BZ);
        step();
        chk_ctl("t1_wait2", RF | AD | BZ);
        step();
        chk_ctl("t1_wait3", RF | AD | BZ);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk_ctl("t1_wb", WR | BZ);
        chk8("t1_wb_dst", dst_addr, 8'h85);
        step();
        chk_ctl("t1_fetch2", RD | BZ);
        chk8("t1_pc", pc, 8'h11);
        step();
        step();
        chk_ctl("t1_halt", HL);
        chk8("t1_halt_pc", pc, 8'h11);

        // SUB then HALT, restart from HALTED
        imem[8'h00] = 32'h10030405;
        imem[8'h01] = 32'hF8000000;
        start_addr = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t2_fetch", RD | BZ);
        chk8("t2_pc0", pc, 8'h00);
        step();
        step();
        chk_ctl("t2_exec", OS | RF | AD | SB | BZ);
        op_done = 1'b1;
        step();
        chk_ctl("t2_wait1", RF | AD | SB | BZ);
        step();
        op_done = 1'b0;
        chk_ctl("t2_wb", WM | BZ);
        chk8("t2_dst", dst_addr, 8'h03);
        step();
        chk8("t2_pc1", pc, 8'h01);
        step();
        step();
        chk_ctl("t2_halt", HL);
        chk8("t2_halt_pc", pc, 8'h01);
        start_addr = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t2_restart", RD | BZ);
        step();
        step();
        chk_ctl("t2_halt2", HL);

        // illegal opcode
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ctl("t3_reset", 13'h0);
        imem[8'h00] = 32'h40000000;
        start_addr = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t3_fetch", RD | BZ);
        step();
        chk_ctl("t3_decode", BZ);
        step();
        chk_ctl("t3_error", ER);
        start_addr = 8'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t3_start_ign", ER);
        chk8("t3_pc", pc, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ctl("t3_clear", 13'h0);

        // MULT timeout, then completion on the last WAIT cycle
        imem[8'h00] = 32'h20000000;
        start_addr = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_ctl("t4_exec", OS | RF | MU | BZ);
        for (int w = 0; w < 4; w++) begin
            step();
            chk_ctl("t4_wait", RF | MU | BZ);
        end
        step();
        chk_ctl("t4_timeout", ER);
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_ctl("t4b_exec", OS | RF | MU | BZ);
        step();
        step();
        step();
        step();
        chk_ctl("t4b_wait4", RF | MU | BZ);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk_ctl("t4b_wb", WM | BZ);
        step();
        chk_ctl("t4b_fetch", RD | BZ);
        chk8("t4b_pc", pc, 8'h01);

        // PC wrap
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem[8'hFF] = 32'h00000000;
        imem[8'h00] = 32'hF8000000;
        start_addr = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        chk8("t5_addr_ff", imem_addr, 8'hFF);
        step();
        step();
        chk_ctl("t5_fetch2", RD | BZ);
        chk8("t5_addr_00", imem_addr, 8'h00);
        step();
        step();
        chk_ctl("t5_halt", HL);
        chk8("t5_pc", pc, 8'h00);

        // reset during WAIT of a SCALE
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem[8'h00] = 32'h18000000;
        start_addr = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start_addr = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl("t6_exec", OS | RF | SC | BZ);
        chk8("t6_pc_busy", pc, 8'h00);
        step();
        chk_ctl("t6_wait1", RF | SC | BZ);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ctl("t6_reset", 13'h0);
        chk8("t6_pc", pc, 8'h00);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk_ctl("t6_late_done", 13'h0);
        step();
        chk_ctl("t6_idle", 13'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
